// File: rtl/base_indicator_7seg.sv
// base_indicator_7seg
// Shows the active number base (decimal / hex / octal / invalid) as a short
// label on a row of 7-segment digits. When a new base is accepted the label
// blinks a fixed number of times and then stays lit.
//
// Segment encoding: digit k occupies segs[7k+6:7k], bit 0 = segment a,
// bit 6 = segment g. The internal image is active-high; the output polarity
// is applied as the very last step.
//
// The FSM state is visible outside the block: `blinking` is a registered
// copy of (state == BLINK).

module base_indicator_7seg #(
  parameter int NUM_DIGITS   = 3,
  parameter int ACTIVE_LOW   = 1,
  parameter int BLINK_CYCLES = 25000000,
  parameter int BLINK_COUNT  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              seletor,
  input  logic                    enable,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    changed,
  output logic                    blinking,
  output logic                    invalid
);

  localparam int SEG_W = 7 * NUM_DIGITS;
  localparam int CNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam int REM_W = (BLINK_COUNT > 1) ? $clog2(2 * BLINK_COUNT) : 1;

  // Blank display as seen on the pins (all segments off after polarity).
  localparam logic [SEG_W-1:0] SEG_BLANK = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [REM_W-1:0] REM_RELOAD = REM_W'(2 * BLINK_COUNT - 1);
  localparam logic [REM_W-1:0] REM_LAST   = REM_W'(1);

  // Active-high glyphs, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] GLYPH_D_LO  = 7'b1011110;  // d
  localparam logic [6:0] GLYPH_E_UP  = 7'b1111001;  // E
  localparam logic [6:0] GLYPH_C_UP  = 7'b0111001;  // C
  localparam logic [6:0] GLYPH_H_UP  = 7'b1110110;  // H
  localparam logic [6:0] GLYPH_H_LO  = 7'b1110100;  // h
  localparam logic [6:0] GLYPH_O_LO  = 7'b1011100;  // o
  localparam logic [6:0] GLYPH_O_UP  = 7'b0111111;  // O
  localparam logic [6:0] GLYPH_C_LO  = 7'b1011000;  // c
  localparam logic [6:0] GLYPH_T_LO  = 7'b1111000;  // t
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;  // -
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  localparam logic [1:0] SEL_DEC = 2'b00;
  localparam logic [1:0] SEL_HEX = 2'b01;
  localparam logic [1:0] SEL_OCT = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;

  typedef enum logic {
    STEADY = 1'b0,
    BLINK  = 1'b1
  } state_t;

  // Synchronizer and FSM registers
  logic [1:0]       sel_meta;
  logic [1:0]       sel_s;
  logic [1:0]       cur_sel;
  state_t           state;
  logic             phase_blank;
  logic [CNT_W-1:0] cnt;
  logic [REM_W-1:0] rem;

  // Next-state values
  logic [1:0]       cur_sel_next;
  state_t           state_next;
  logic             phase_blank_next;
  logic [CNT_W-1:0] cnt_next;
  logic [REM_W-1:0] rem_next;
  logic             changed_next;

  // Next output values
  logic [SEG_W-1:0] label_img;
  logic [SEG_W-1:0] image_next;
  logic [SEG_W-1:0] segs_next;
  logic             blinking_next;
  logic             invalid_next;

  // Glyph for digit position k given a base selection. Wide displays show a
  // three-letter label on digits 2..0; narrow displays show one letter on
  // digit 0. Every other position is blank.
  function automatic logic [6:0] digit_glyph(input logic [1:0] sel, input int k);
    logic [6:0] g;
    g = GLYPH_BLANK;
    if (NUM_DIGITS >= 3) begin
      case (sel)
        SEL_DEC: begin
          if (k == 2)      g = GLYPH_D_LO;
          else if (k == 1) g = GLYPH_E_UP;
          else if (k == 0) g = GLYPH_C_UP;
        end
        SEL_HEX: begin
          // "HEX" with the X drawn as H, since X has no 7-segment form.
          if (k == 2)      g = GLYPH_H_UP;
          else if (k == 1) g = GLYPH_E_UP;
          else if (k == 0) g = GLYPH_H_UP;
        end
        SEL_OCT: begin
          if (k == 2)      g = GLYPH_O_UP;
          else if (k == 1) g = GLYPH_C_LO;
          else if (k == 0) g = GLYPH_T_LO;
        end
        default: begin
          if (k <= 2) g = GLYPH_DASH;
        end
      endcase
    end else if (k == 0) begin
      case (sel)
        SEL_DEC: g = GLYPH_D_LO;
        SEL_HEX: g = GLYPH_H_LO;
        SEL_OCT: g = GLYPH_O_LO;
        default: g = GLYPH_DASH;
      endcase
    end
    return g;
  endfunction

  // Label image for the base that will be held after this edge.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign label_img[7*k +: 7] = digit_glyph(cur_sel_next, k);
  end

  // Two-flop synchronizer for the asynchronous base selector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta <= SEL_DEC;
      sel_s    <= SEL_DEC;
    end else begin
      sel_meta <= seletor;
      sel_s    <= sel_meta;
    end
  end

  // State register: accepted base, FSM state, blink phase and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel     <= SEL_DEC;
      state       <= STEADY;
      phase_blank <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
    end else begin
      cur_sel     <= cur_sel_next;
      state       <= state_next;
      phase_blank <= phase_blank_next;
      cnt         <= cnt_next;
      rem         <= rem_next;
    end
  end

  // Next-state logic: disable override, change detection, blink sequencing.
  always_comb begin
    cur_sel_next     = cur_sel;
    state_next       = state;
    phase_blank_next = phase_blank;
    cnt_next         = cnt;
    rem_next         = rem;
    changed_next     = 1'b0;

    if (!enable) begin
      // Display off: track the selector silently, no blink pending.
      cur_sel_next     = sel_s;
      state_next       = STEADY;
      phase_blank_next = 1'b0;
      cnt_next         = '0;
      rem_next         = '0;
    end else if (sel_s != cur_sel) begin
      // New base accepted (also restarts a blink already in progress).
      cur_sel_next     = sel_s;
      changed_next     = 1'b1;
      state_next       = BLINK;
      phase_blank_next = 1'b1;
      cnt_next         = CNT_RELOAD;
      rem_next         = REM_RELOAD;
    end else if (state == BLINK) begin
      if (cnt == '0) begin
        if (rem <= REM_LAST) begin
          // Last blink phase done; the final visible phase is the steady one.
          state_next       = STEADY;
          phase_blank_next = 1'b0;
          cnt_next         = '0;
          rem_next         = '0;
        end else begin
          phase_blank_next = ~phase_blank;
          cnt_next         = CNT_RELOAD;
          rem_next         = rem - REM_W'(1);
        end
      end else begin
        cnt_next = cnt - CNT_W'(1);
      end
    end
  end

  // Output logic: image from next state, polarity applied last.
  always_comb begin
    image_next = label_img;
    if (!enable || ((state_next == BLINK) && phase_blank_next)) begin
      image_next = '0;
    end
    segs_next     = (ACTIVE_LOW != 0) ? ~image_next : image_next;
    blinking_next = (state_next == BLINK);
    invalid_next  = (cur_sel_next == SEL_BAD);
  end

  // Output registers, updated on the same edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segs     <= SEG_BLANK;
      changed  <= 1'b0;
      blinking <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      segs     <= segs_next;
      changed  <= changed_next;
      blinking <= blinking_next;
      invalid  <= invalid_next;
    end
  end

endmodule

// File: tb/tb_base_indicator_7seg.sv
// Bench for base_indicator_7seg with NUM_DIGITS=3, ACTIVE_LOW=1,
// BLINK_CYCLES=4, BLINK_COUNT=2. Expected outputs are written per cycle from
// the documented timeline and queued when the stimulus is driven; each queued
// entry is compared on the cycle it is due.

module tb_base_indicator_7seg;

  localparam int ND = 3;
  localparam int W  = 7 * ND;

  localparam logic [6:0] G_D  = 7'b1011110;
  localparam logic [6:0] G_E  = 7'b1111001;
  localparam logic [6:0] G_CU = 7'b0111001;
  localparam logic [6:0] G_H  = 7'b1110110;
  localparam logic [6:0] G_OU = 7'b0111111;
  localparam logic [6:0] G_CL = 7'b1011000;
  localparam logic [6:0] G_T  = 7'b1111000;
  localparam logic [6:0] G_DS = 7'b1000000;

  // Pin-level (active-low) images.
  localparam logic [W-1:0] L_DEC  = ~{G_D, G_E, G_CU};
  localparam logic [W-1:0] L_HEH  = ~{G_H, G_E, G_H};
  localparam logic [W-1:0] L_OCT  = ~{G_OU, G_CL, G_T};
  localparam logic [W-1:0] L_DASH = ~{G_DS, G_DS, G_DS};
  localparam logic [W-1:0] L_OFF  = {W{1'b1}};

  logic         clk;
  logic         rst_n;
  logic [1:0]   seletor;
  logic         enable;
  logic [W-1:0] segs;
  logic         changed;
  logic         blinking;
  logic         invalid;

  base_indicator_7seg #(
    .NUM_DIGITS   (ND),
    .ACTIVE_LOW   (1),
    .BLINK_CYCLES (4),
    .BLINK_COUNT  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seletor  (seletor),
    .enable   (enable),
    .segs     (segs),
    .changed  (changed),
    .blinking (blinking),
    .invalid  (invalid)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {tag[7:0], cycle[15:0], segs[20:0], changed, blinking, invalid}
  logic [47:0] exp_q[$];
  int          cyc;
  int          vectors;
  int          miscompares;

  typedef struct {
    logic [1:0]   sel;
    logic         en;
    logic [W-1:0] segs;
    logic         inv;
  } vec_t;

  vec_t vecs[7];

  task automatic compare(input int tag, input logic [W-1:0] e_segs,
                         input logic e_chg, input logic e_blk, input logic e_inv);
    vectors++;
    if (segs !== e_segs || changed !== e_chg || blinking !== e_blk || invalid !== e_inv) begin
      miscompares++;
      $display("FAIL tag=%0d cyc=%0d segs=%h exp %h changed=%b exp %b blinking=%b exp %b invalid=%b exp %b",
               tag, cyc, segs, e_segs, changed, e_chg, blinking, e_blk, invalid, e_inv);
    end
  endtask

  task automatic expect_span(input int tag, input int from, input int to,
                             input logic [W-1:0] e_segs, input logic e_chg,
                             input logic e_blk, input logic e_inv);
    for (int c = from; c <= to; c++) begin
      exp_q.push_back({tag[7:0], c[15:0], e_segs, e_chg, e_blk, e_inv});
    end
  endtask

  // Compare every queued expectation that is due this cycle.
  task automatic check_due();
    int i;
    logic [47:0] e;
    i = 0;
    while (i < exp_q.size()) begin
      e = exp_q[i];
      if (int'(e[39:24]) == cyc) begin
        compare(int'(e[47:40]), e[23:3], e[2], e[1], e[0]);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  // One clock: sample outputs 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check_due();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int t;
    int r;

    // Steady-state table: inputs and the settled outputs 16 cycles later.
    vecs[0] = '{sel: 2'b01, en: 1'b1, segs: L_HEH,  inv: 1'b0};
    vecs[1] = '{sel: 2'b10, en: 1'b1, segs: L_OCT,  inv: 1'b0};
    vecs[2] = '{sel: 2'b11, en: 1'b1, segs: L_DASH, inv: 1'b1};
    vecs[3] = '{sel: 2'b00, en: 1'b1, segs: L_DEC,  inv: 1'b0};
    vecs[4] = '{sel: 2'b10, en: 1'b0, segs: L_OFF,  inv: 1'b0};
    vecs[5] = '{sel: 2'b11, en: 1'b0, segs: L_OFF,  inv: 1'b1};
    vecs[6] = '{sel: 2'b01, en: 1'b1, segs: L_HEH,  inv: 1'b0};

    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    seletor     = 2'b00;
    enable      = 1'b1;

    // Reset state, then release: dEC on the first edge.
    ticks(3);
    compare(1, L_OFF, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    expect_span(2, cyc + 1, cyc + 3, L_DEC, 1'b0, 1'b0, 1'b0);
    ticks(3);

    // 00 -> 01: changed at T+3, blank/visible/blank, steady from T+15.
    t = cyc;
    seletor = 2'b01;
    expect_span(3, t + 1,  t + 2,  L_DEC, 1'b0, 1'b0, 1'b0);
    expect_span(3, t + 3,  t + 3,  L_OFF, 1'b1, 1'b1, 1'b0);
    expect_span(3, t + 4,  t + 6,  L_OFF, 1'b0, 1'b1, 1'b0);
    expect_span(3, t + 7,  t + 10, L_HEH, 1'b0, 1'b1, 1'b0);
    expect_span(3, t + 11, t + 14, L_OFF, 1'b0, 1'b1, 1'b0);
    expect_span(3, t + 15, t + 17, L_HEH, 1'b0, 1'b0, 1'b0);
    ticks(17);

    // 01 -> 10, then 10 -> 00 at T+6: restart at T+9, steady dEC from T+21.
    t = cyc;
    seletor = 2'b10;
    expect_span(4, t + 1,  t + 2,  L_HEH, 1'b0, 1'b0, 1'b0);
    expect_span(4, t + 3,  t + 3,  L_OFF, 1'b1, 1'b1, 1'b0);
    expect_span(4, t + 4,  t + 6,  L_OFF, 1'b0, 1'b1, 1'b0);
    expect_span(4, t + 7,  t + 8,  L_OCT, 1'b0, 1'b1, 1'b0);
    expect_span(4, t + 9,  t + 9,  L_OFF, 1'b1, 1'b1, 1'b0);
    expect_span(4, t + 10, t + 12, L_OFF, 1'b0, 1'b1, 1'b0);
    expect_span(4, t + 13, t + 16, L_DEC, 1'b0, 1'b1, 1'b0);
    expect_span(4, t + 17, t + 20, L_OFF, 1'b0, 1'b1, 1'b0);
    expect_span(4, t + 21, t + 22, L_DEC, 1'b0, 1'b0, 1'b0);
    ticks(6);
    seletor = 2'b00;
    ticks(16);

    // Invalid base: dashes after the blink, invalid drops on the accepting edge.
    t = cyc;
    seletor = 2'b11;
    expect_span(5, t + 1,  t + 2,  L_DEC,  1'b0, 1'b0, 1'b0);
    expect_span(5, t + 3,  t + 3,  L_OFF,  1'b1, 1'b1, 1'b1);
    expect_span(5, t + 7,  t + 10, L_DASH, 1'b0, 1'b1, 1'b1);
    expect_span(5, t + 15, t + 16, L_DASH, 1'b0, 1'b0, 1'b1);
    ticks(16);
    t = cyc;
    seletor = 2'b00;
    expect_span(6, t + 1,  t + 2,  L_DASH, 1'b0, 1'b0, 1'b1);
    expect_span(6, t + 3,  t + 3,  L_OFF,  1'b1, 1'b1, 1'b0);
    expect_span(6, t + 15, t + 16, L_DEC,  1'b0, 1'b0, 1'b0);
    ticks(16);

    // Disabled: blank, no pulse; re-enable shows Oct at once without blink.
    t = cyc;
    enable  = 1'b0;
    seletor = 2'b10;
    expect_span(7, t + 1, t + 5, L_OFF, 1'b0, 1'b0, 1'b0);
    expect_span(7, t + 6, t + 9, L_OCT, 1'b0, 1'b0, 1'b0);
    ticks(5);
    enable = 1'b1;
    ticks(4);

    // Reset during a blink: immediate blank, clean dEC after release.
    t = cyc;
    seletor = 2'b01;
    expect_span(8, t + 1, t + 2, L_OCT, 1'b0, 1'b0, 1'b0);
    expect_span(8, t + 3, t + 3, L_OFF, 1'b1, 1'b1, 1'b0);
    expect_span(8, t + 4, t + 6, L_OFF, 1'b0, 1'b1, 1'b0);
    expect_span(8, t + 7, t + 8, L_HEH, 1'b0, 1'b1, 1'b0);
    ticks(8);
    rst_n   = 1'b0;
    seletor = 2'b00;
    #1;
    compare(9, L_OFF, 1'b0, 1'b0, 1'b0);
    ticks(2);
    compare(9, L_OFF, 1'b0, 1'b0, 1'b0);
    r = cyc;
    rst_n = 1'b1;
    expect_span(10, r + 1, r + 8, L_DEC, 1'b0, 1'b0, 1'b0);
    ticks(8);

    // Table of settled results.
    for (int i = 0; i < 7; i++) begin
      seletor = vecs[i].sel;
      enable  = vecs[i].en;
      expect_span(100 + i, cyc + 16, cyc + 16, vecs[i].segs, 1'b0, 1'b0, vecs[i].inv);
      ticks(16);
    end

    // Anything still queued was never reached.
    while (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unchecked tag=%0d due cyc=%0d now %0d",
               int'(exp_q[0][47:40]), int'(exp_q[0][39:24]), cyc);
      void'(exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
